// File: rtl/fetch_queue.sv
// Fetch stage: free-running PC issuing reads to a one-cycle-latency instruction
// memory, with returned instructions (and their PC+1) buffered in a DEPTH-entry FIFO.
module fetch_queue #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]           imem_rdata,
    output logic                         instr_valid,
    output logic [INSTR_W-1:0]           instr,
    output logic [ADDR_W-1:0]            next_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]  pc;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_npc;
    logic [ADDR_W-1:0]  issue_npc;

    logic [INSTR_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0]  q_npc   [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   count;
    logic [OCC_W:0]     credit_used;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits count both stored entries and the return still in flight, so a
    // push can never land on a full FIFO; a same-cycle pop frees nothing yet.
    always_comb begin
        credit_used = {1'b0, count} + (OCC_W + 1)'(inflight);
        imem_req    = 1'b0;
        imem_addr   = pc;
        if (rst) begin
            imem_req = 1'b0;
        end else if (redirect) begin
            imem_req  = 1'b1;
            imem_addr = redirect_pc;
        end else begin
            imem_req = credit_used < (OCC_W + 1)'(DEPTH);
        end
        issue_npc = imem_addr + ADDR_W'(1);
        push      = inflight && !redirect && !rst;
        pop       = (count != '0) && !stall && !redirect && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_npc <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc           <= issue_npc;
                inflight_npc <= issue_npc;
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                if (push && !pop)      count <= count + OCC_W'(1);
                else if (pop && !push) count <= count - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_npc[wr_ptr]   <= inflight_npc;
        end
    end

    assign instr_valid = (count != '0);
    assign instr       = q_instr[rd_ptr];
    assign next_pc     = q_npc[rd_ptr];
    assign occupancy   = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: three instances (DEPTH 4, 2, 8) share one stimulus
// stream; each has its own memory model returning mem[a] = a ^ 16'hA5A5.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic        req4, req2, req8;
    logic [15:0] addr4, addr2, addr8;
    logic [15:0] rdata4, rdata2, rdata8;
    logic        valid4, valid2, valid8;
    logic [15:0] instr4, instr2, instr8;
    logic [15:0] npc4, npc2, npc8;
    logic [2:0]  occ4;
    logic [1:0]  occ2;
    logic [3:0]  occ8;

    int          vectors    = 0;
    int          miscompares = 0;
    logic        mon_en;
    logic [15:0] exp4, exp2, exp8;

    fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(req4), .imem_addr(addr4), .imem_rdata(rdata4),
        .instr_valid(valid4), .instr(instr4), .next_pc(npc4), .occupancy(occ4)
    );
    fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(2), .RESET_PC(16'h0000)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(req2), .imem_addr(addr2), .imem_rdata(rdata2),
        .instr_valid(valid2), .instr(instr2), .next_pc(npc2), .occupancy(occ2)
    );
    fetch_queue #(.ADDR_W(16), .INSTR_W(16), .DEPTH(8), .RESET_PC(16'h0000)) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(req8), .imem_addr(addr8), .imem_rdata(rdata8),
        .instr_valid(valid8), .instr(instr8), .next_pc(npc8), .occupancy(occ8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rdata4 <= addr4 ^ 16'hA5A5;
        rdata2 <= addr2 ^ 16'hA5A5;
        rdata8 <= addr8 ^ 16'hA5A5;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        #2;
    endtask

    // Every popped entry must continue the expected address stream in order.
    task automatic tick();
        chk("occ4_bound", occ4 <= 3'd4, 1);
        chk("occ2_bound", occ2 <= 2'd2, 1);
        chk("occ8_bound", occ8 <= 4'd8, 1);
        if (mon_en && !stall && !redirect && !rst) begin
            if (valid4) begin
                chk("d4_pop_npc", npc4, exp4);
                chk("d4_pop_instr", instr4, (exp4 - 16'd1) ^ 16'hA5A5);
                exp4 = exp4 + 16'd1;
            end
            if (valid2) begin
                chk("d2_pop_npc", npc2, exp2);
                chk("d2_pop_instr", instr2, (exp2 - 16'd1) ^ 16'hA5A5);
                exp2 = exp2 + 16'd1;
            end
            if (valid8) begin
                chk("d8_pop_npc", npc8, exp8);
                chk("d8_pop_instr", instr8, (exp8 - 16'd1) ^ 16'hA5A5);
                exp8 = exp8 + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        mon_en = 1'b0;
        exp4 = 16'd1; exp2 = 16'd1; exp8 = 16'd1;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(posedge clk);
        #1;

        // Reset and fill
        drive(1, 0, 0, 16'h0000);
        chk("rst_req4", req4, 0);
        chk("rst_req2", req2, 0);
        chk("rst_req8", req8, 0);
        tick();
        drive(0, 0, 0, 16'h0000);
        mon_en = 1'b1;
        chk("a0_occ4", occ4, 0);
        chk("a0_valid4", valid4, 0);
        chk("a0_req4", req4, 1);
        chk("a0_addr4", addr4, 16'h0000);
        tick();
        chk("a1_addr4", addr4, 16'h0001);
        chk("a1_valid4", valid4, 0);
        tick();
        chk("a2_valid4", valid4, 1);
        chk("a2_instr4", instr4, 16'hA5A5);
        chk("a2_npc4", npc4, 16'h0001);
        chk("a2_addr4", addr4, 16'h0002);
        tick();

        // Stall saturation
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 16'h0000);
            chk("stall_valid4", valid4, 1);
            chk("stall_instr4", instr4, 16'hA5A4);
            chk("stall_npc4", npc4, 16'h0002);
            if (i >= 2) chk("stall_req4", req4, 0);
            if (i == 9) begin
                chk("sat_occ4", occ4, 4);
                chk("sat_occ2", occ2, 2);
                chk("sat_occ8", occ8, 8);
                chk("sat_req2", req2, 0);
                chk("sat_req8", req8, 0);
                chk("sat_npc2", npc2, 16'h0002);
                chk("sat_npc8", npc8, 16'h0002);
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 16'h0000);
            chk("drain_valid4", valid4, 1);
            chk("drain_npc4", npc4, 16'h0002 + 16'(i));
            tick();
        end
        mon_en = 1'b0;

        // Redirect with three entries queued
        drive(1, 0, 0, 16'h0000); tick();
        drive(0, 0, 0, 16'h0000); tick();
        tick();
        drive(0, 1, 0, 16'h0000); tick();
        tick();
        drive(0, 0, 1, 16'h0040);
        chk("r0_occ4", occ4, 3);
        chk("r0_req4", req4, 1);
        chk("r0_addr4", addr4, 16'h0040);
        tick();
        drive(0, 0, 0, 16'h0000);
        chk("r1_occ4", occ4, 0);
        chk("r1_valid4", valid4, 0);
        chk("r1_addr4", addr4, 16'h0041);
        tick();
        chk("r2_valid4", valid4, 1);
        chk("r2_instr4", instr4, 16'hA5E5);
        chk("r2_npc4", npc4, 16'h0041);
        tick();
        chk("r3_npc4", npc4, 16'h0042);
        chk("r3_instr4", instr4, 16'hA5E4);
        tick();

        // Redirect with stall, then back-to-back redirects
        drive(0, 1, 1, 16'h0010);
        chk("t0_req4", req4, 1);
        chk("t0_addr4", addr4, 16'h0010);
        tick();
        drive(0, 0, 0, 16'h0000);
        chk("t1_occ4", occ4, 0);
        chk("t1_valid4", valid4, 0);
        tick();
        chk("t2_valid4", valid4, 1);
        chk("t2_npc4", npc4, 16'h0011);
        chk("t2_instr4", instr4, 16'hA5B5);
        tick();
        drive(0, 0, 1, 16'h0010); tick();
        drive(0, 0, 1, 16'h0020);
        chk("t4_addr4", addr4, 16'h0020);
        tick();
        drive(0, 0, 0, 16'h0000);
        chk("t5_valid4", valid4, 0);
        chk("t5_occ4", occ4, 0);
        tick();
        chk("t6_valid4", valid4, 1);
        chk("t6_npc4", npc4, 16'h0021);
        chk("t6_instr4", instr4, 16'hA585);
        tick();
        chk("t7_npc4", npc4, 16'h0022);
        chk("t7_instr4", instr4, 16'hA584);
        tick();

        // PC wrap
        drive(0, 0, 1, 16'hFFFE);
        chk("u0_addr4", addr4, 16'hFFFE);
        tick();
        drive(0, 0, 0, 16'h0000);
        chk("u1_addr4", addr4, 16'hFFFF);
        tick();
        chk("u2_addr4", addr4, 16'h0000);
        chk("u2_npc4", npc4, 16'hFFFF);
        chk("u2_instr4", instr4, 16'h5A5B);
        tick();
        chk("u3_npc4", npc4, 16'h0000);
        chk("u3_instr4", instr4, 16'h5A5A);
        tick();
        chk("u4_npc4", npc4, 16'h0001);
        chk("u4_instr4", instr4, 16'hA5A5);
        tick();

        // Reset with a full queue, stall held and a redirect pending
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 16'h0000);
            tick();
        end
        drive(0, 1, 0, 16'h0000);
        chk("full_occ4", occ4, 4);
        chk("full_occ2", occ2, 2);
        chk("full_req4", req4, 0);
        tick();
        drive(1, 1, 1, 16'h0080);
        chk("mid_rst_req4", req4, 0);
        chk("mid_rst_req2", req2, 0);
        chk("mid_rst_req8", req8, 0);
        tick();
        drive(0, 1, 0, 16'h0000);
        chk("v0_occ4", occ4, 0);
        chk("v0_valid4", valid4, 0);
        chk("v0_occ2", occ2, 0);
        chk("v0_valid2", valid2, 0);
        chk("v0_occ8", occ8, 0);
        chk("v0_valid8", valid8, 0);
        chk("v0_req4", req4, 1);
        chk("v0_addr4", addr4, 16'h0000);
        tick();
        drive(0, 0, 0, 16'h0000);
        chk("v1_addr4", addr4, 16'h0001);
        tick();
        chk("v2_valid4", valid4, 1);
        chk("v2_npc4", npc4, 16'h0001);
        chk("v2_instr4", instr4, 16'hA5A5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
